// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO that paces bursts into uart_tx one frame at a time
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   wr_en_i, wr_d_i       producer write strobe and byte
//   full_o, empty_o       FIFO holds DEPTH / 0 entries
//   level_o               entry count 0..DEPTH
//   ovf_o                 sticky: a write arrived while full and was dropped
//   tx_e_o, tx_d_o        one-cycle launch pulse and held byte to uart_tx
//   tx_busy_i             uart_tx busy
//   drop_cnt_o            saturating count of dropped writes (UART_TX_FIFO_DROP_CNT_EN only)
module uart_tx_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int DATA_W     = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en_i,
  input  logic [DATA_W-1:0]     wr_d_i,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [DEPTH_LOG2:0]   level_o,
  output logic                  ovf_o,
  output logic                  tx_e_o,
  output logic [DATA_W-1:0]     tx_d_o,
`ifdef UART_TX_FIFO_DROP_CNT_EN
  output logic [7:0]            drop_cnt_o,
`endif
  input  logic                  tx_busy_i
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  typedef enum logic [1:0] {IDLE, WAIT_START, WAIT_END} state_t;
  state_t r_state, w_next;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DEPTH_LOG2:0] r_wr_ptr, r_rd_ptr, w_level;
  logic [DATA_W-1:0] r_tx_d;
  logic r_tx_e, r_ovf, r_to;
  logic w_full, w_empty, w_wr, w_pop;
  assign w_level = r_wr_ptr - r_rd_ptr;
  // level never exceeds DEPTH, so its top bit is set only when full
  assign w_full  = w_level[DEPTH_LOG2];
  assign w_empty = w_level == '0;
  assign w_wr    = wr_en_i & ~w_full;
  assign w_pop   = (r_state == IDLE) & ~w_empty & ~tx_busy_i;
  // WAIT_START gives up after two busy-low cycles so a silent uart_tx cannot hang the queue
  always_comb begin
    w_next = r_state == IDLE       ? (w_pop ? WAIT_START : IDLE) :
             r_state == WAIT_START ? (tx_busy_i ? WAIT_END : r_to ? IDLE : WAIT_START) :
                                     (tx_busy_i ? WAIT_END : IDLE);
  end
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr[DEPTH_LOG2-1:0]] <= wr_d_i;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_tx_e   <= 1'b0;
      r_tx_d   <= '0;
      r_ovf    <= 1'b0;
      r_to     <= 1'b0;
    end else begin
      r_state <= w_next;
      r_tx_e  <= w_pop;
      r_to    <= (r_state == WAIT_START) & ~tx_busy_i & ~r_to;
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (wr_en_i & w_full) r_ovf <= 1'b1;
      if (w_pop) begin
        r_tx_d   <= r_mem[r_rd_ptr[DEPTH_LOG2-1:0]];
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end
`ifdef UART_TX_FIFO_DROP_CNT_EN
  logic [7:0] r_drop_cnt;
  always_ff @(posedge clk) begin
    if (reset) r_drop_cnt <= '0;
    else if (wr_en_i & w_full & (r_drop_cnt != 8'hFF)) r_drop_cnt <= r_drop_cnt + 1'b1;
  end
  assign drop_cnt_o = r_drop_cnt;
`endif
  assign full_o  = w_full;
  assign empty_o = w_empty;
  assign level_o = w_level;
  assign ovf_o   = r_ovf;
  assign tx_e_o  = r_tx_e;
  assign tx_d_o  = r_tx_d;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed and random checks of uart_tx_fifo against a queue model and a uart_tx busy model
module tb_uart_tx_fifo;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic wr_en_i = 1'b0;
  logic [7:0] wr_d_i = '0;
  logic tx_busy_i = 1'b0;
  logic full_o, empty_o, ovf_o, tx_e_o;
  logic [4:0] level_o;
  logic [7:0] tx_d_o;
`ifdef UART_TX_FIFO_DROP_CNT_EN
  logic [7:0] drop_cnt_o;
`endif

  uart_tx_fifo dut (
    .clk(clk),
    .reset(reset),
    .wr_en_i(wr_en_i),
    .wr_d_i(wr_d_i),
    .full_o(full_o),
    .empty_o(empty_o),
    .level_o(level_o),
    .ovf_o(ovf_o),
    .tx_e_o(tx_e_o),
    .tx_d_o(tx_d_o),
`ifdef UART_TX_FIFO_DROP_CNT_EN
    .drop_cnt_o(drop_cnt_o),
`endif
    .tx_busy_i(tx_busy_i)
  );

  always #5 clk = ~clk;

  int cmp = 0;
  int mis = 0;
  int cyc = 0;
  int acc, pulses, drops, busy_left, busy_len, fall_edge, last_pulse, prev_pulse, max_level;
  bit force_busy, prev_e, in_frame, saw_high, m_ovf;
  logic [7:0] exp_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp++;
    assert (obs === exp) else begin
      mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    acc = 0; pulses = 0; drops = 0; busy_left = 0; force_busy = 0;
    prev_e = 0; in_frame = 0; saw_high = 0; m_ovf = 0;
    fall_edge = -1; last_pulse = -100; prev_pulse = -100; max_level = 0;
    exp_q.delete();
    tx_busy_i = 1'b0;
    wr_en_i = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    wr_en_i = 1'b0;
    tx_busy_i = 1'b0;
    @(posedge clk); #1; cyc++;
    chk("rst_tx_e", tx_e_o, 0);
    chk("rst_tx_d", tx_d_o, 0);
    chk("rst_empty", empty_o, 1);
    chk("rst_full", full_o, 0);
    chk("rst_level", level_o, 0);
    chk("rst_ovf", ovf_o, 0);
`ifdef UART_TX_FIFO_DROP_CNT_EN
    chk("rst_drop_cnt", drop_cnt_o, 0);
`endif
    clear_model();
    reset = 1'b0;
  endtask

  // one clock: model the write, score any launch, check flags, then model uart_tx busy
  task automatic tick();
    logic b, w;
    logic [7:0] d;
    int lvl;
    b = tx_busy_i; w = wr_en_i; d = wr_d_i;
    @(posedge clk); #1; cyc++;
    if (w) begin
      if (acc - pulses < 16) begin exp_q.push_back(d); acc++; end
      else begin m_ovf = 1; if (drops < 255) drops++; end
    end
    if (in_frame && b) saw_high = 1;
    else if (in_frame && saw_high) begin fall_edge = cyc; in_frame = 0; saw_high = 0; end
    if (tx_e_o === 1'b1) begin
      chk("e_not_back_to_back", prev_e, 0);
      chk("busy_low_at_launch", b, 0);
      chk("launch_after_busy_fall", cyc > fall_edge, 1);
      chk("launch_has_data", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) chk("tx_d_order", tx_d_o, exp_q.pop_front());
      pulses++;
      prev_pulse = last_pulse; last_pulse = cyc;
      in_frame = 1; saw_high = 0;
    end
    lvl = acc - pulses;
    if (lvl > max_level) max_level = lvl;
    chk("level", level_o, lvl);
    chk("full", full_o, lvl == 16);
    chk("empty", empty_o, lvl == 0);
    chk("ovf", ovf_o, m_ovf);
`ifdef UART_TX_FIFO_DROP_CNT_EN
    chk("drop_cnt", drop_cnt_o, drops);
`endif
    if (prev_e) busy_left = busy_len;
    else if (busy_left > 0) busy_left--;
    prev_e = tx_e_o;
    tx_busy_i = force_busy || busy_left > 0;
  endtask

  task automatic wr(input logic [7:0] d);
    wr_en_i = 1'b1;
    wr_d_i = d;
    tick();
    wr_en_i = 1'b0;
  endtask

  initial begin
    do_reset();

    busy_len = 10;
    wr(8'hA5);
    chk("single_no_early_e", tx_e_o, 0);
    tick();
    chk("single_e", tx_e_o, 1);
    chk("single_d", tx_d_o, 8'hA5);
    repeat (20) tick();
    chk("single_pulses", pulses, 1);
    chk("single_empty", empty_o, 1);

    do_reset();
    busy_len = 20;
    for (int i = 0; i < 16; i++) wr(8'(i));
    chk("burst_level", level_o, 15);
    repeat (420) tick();
    chk("burst_pulses", pulses, 16);
    chk("burst_ovf", ovf_o, 0);
    chk("burst_drained", exp_q.size(), 0);

    do_reset();
    busy_len = 3;
    force_busy = 1;
    tx_busy_i = 1'b1;
    for (int i = 0; i < 17; i++) wr(8'($urandom));
    chk("ovf_level", level_o, 16);
    chk("ovf_full", full_o, 1);
    chk("ovf_flag", ovf_o, 1);
`ifdef UART_TX_FIFO_DROP_CNT_EN
    chk("ovf_drop_cnt", drop_cnt_o, 1);
`endif
    force_busy = 0;
    tx_busy_i = 1'b0;
    repeat (200) tick();
    chk("ovf_pulses", pulses, 16);
    chk("ovf_drained", exp_q.size(), 0);

    do_reset();
    busy_len = 20;
    for (int i = 0; i < 40; i++) begin
      wr(8'($urandom));
      repeat (24) tick();
    end
    repeat (30) tick();
    chk("wrap_pulses", pulses, 40);
    chk("wrap_max_level", max_level <= 2, 1);

    do_reset();
    busy_len = 0;
    wr(8'h3C);
    wr(8'h3D);
    repeat (10) tick();
    chk("nobusy_pulses", pulses, 2);
    chk("nobusy_spacing", last_pulse - prev_pulse, 3);

    do_reset();
    busy_len = 20;
    for (int i = 0; i < 5; i++) wr(8'($urandom));
    repeat (6) tick();
    do_reset();
    repeat (40) tick();
    chk("midrst_no_launch", pulses, 0);
    chk("midrst_empty", empty_o, 1);

    do_reset();
    busy_len = $urandom_range(1, 12);
    for (int i = 0; i < 400; i++) begin
      wr_en_i = ($urandom_range(0, 3) == 0);
      wr_d_i = 8'($urandom);
      tick();
    end
    wr_en_i = 1'b0;
    repeat (500) tick();
    chk("rand_drained", exp_q.size(), 0);
    chk("rand_pulses", pulses, acc);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mis);
    $finish;
  end
endmodule
